// File: rtl/pov_pkg.sv
// Shared definitions for the POV column sequencer: ROM geometry,
// default column/frame split and the sequencer state encoding.
package pov_pkg;

   localparam int ROM_AWIDTH     = 11;
   localparam int ROM_DWIDTH     = 16;
   localparam int COL_BITS_DEF   = 7;
   localparam int FRAME_BITS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/hall_sync_edge.sv
// Hall index conditioning: two-flop synchronizer followed by a
// rising-edge detector that yields a single-cycle pulse.
module hall_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   // Shift the raw input through the synchronizer and one history stage.
   always_comb begin
      sync_d = {sync_q[1:0], async_in};
   end

   // Synchronizer and history flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pov_column_sequencer.sv
// POV column sequencer: measures the revolution period from the hall
// index and issues one ROM read per column slot at address {frame, col}.
// Build option POV_MIRROR_EN reverses the column field of the address.
module pov_column_sequencer
   import pov_pkg::*;
#(
   parameter int COL_BITS    = COL_BITS_DEF,
   parameter int FRAME_BITS  = FRAME_BITS_DEF,
   parameter int PER_W       = 24,
   parameter int MIN_COL_PER = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hall_in,
   input  logic [FRAME_BITS-1:0] frame_sel,
   output logic                  leer_rom,
   output logic [ROM_AWIDTH-1:0] dir_rom,
   output logic                  col_valid,
   output logic                  running
);

   localparam logic [PER_W-1:0] PER_MAX = '1;
   localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
   localparam logic [PER_W-1:0] MIN_CP  = PER_W'(MIN_COL_PER);
   localparam logic [COL_BITS:0] COL_ONE = (COL_BITS + 1)'(1);

   logic                  idx;
   state_t                state_q, state_d;
   logic [PER_W-1:0]      per_cnt_q, per_cnt_d;
   logic [PER_W-1:0]      period_q, period_d;
   logic [PER_W-1:0]      col_tmr_q, col_tmr_d;
   logic [COL_BITS:0]     col_q, col_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic                  leer_q, leer_d;
   logic [ROM_AWIDTH-1:0] dir_q, dir_d;
   logic                  col_valid_q, col_valid_d;
   logic                  running_q, running_d;

   logic [PER_W-1:0]      per_inc;
   logic [PER_W-1:0]      col_per;
   logic [PER_W-1:0]      new_col_per;
   logic                  per_sat;

   // Map a column index to the address column field (reversed when mirrored).
   function automatic logic [COL_BITS-1:0] col_map(input logic [COL_BITS-1:0] c);
`ifdef POV_MIRROR_EN
      return ~c;
`else
      return c;
`endif
   endfunction

   hall_sync_edge u_hall (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_in(hall_in),
      .pulse   (idx)
   );

   assign per_inc     = per_cnt_q + PER_ONE;
   assign per_sat     = (per_cnt_q == PER_MAX);
   assign col_per     = period_q >> COL_BITS;
   assign new_col_per = per_inc >> COL_BITS;

   // Next-state logic: period measurement, lock decision and column pacing.
   always_comb begin
      state_d   = state_q;
      per_cnt_d = per_sat ? per_cnt_q : per_inc;
      period_d  = period_q;
      col_tmr_d = col_tmr_q;
      col_d     = col_q;
      frame_d   = frame_q;
      leer_d    = 1'b0;
      dir_d     = dir_q;

      if (idx) begin
         per_cnt_d = '0;
         period_d  = per_inc;
         frame_d   = frame_sel;
      end

      case (state_q)
         IDLE: begin
            if (idx) begin
               state_d = SYNC;
            end
         end
         SYNC, RUN: begin
            if (idx) begin
               // Restart at column 0 on every index, or drop lock if too fast.
               if (new_col_per >= MIN_CP) begin
                  state_d   = RUN;
                  leer_d    = 1'b1;
                  dir_d     = {frame_sel, col_map('0)};
                  col_d     = COL_ONE;
                  col_tmr_d = '0;
               end else begin
                  state_d = SYNC;
               end
            end else if (state_q == RUN && !col_q[COL_BITS]) begin
               if (col_tmr_q == col_per - PER_ONE) begin
                  leer_d    = 1'b1;
                  dir_d     = {frame_q, col_map(col_q[COL_BITS-1:0])};
                  col_d     = col_q + COL_ONE;
                  col_tmr_d = '0;
               end else begin
                  col_tmr_d = col_tmr_q + PER_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A stalled rotor drops everything back to IDLE.
      if (per_sat && !idx) begin
         state_d = IDLE;
         leer_d  = 1'b0;
      end

      col_valid_d = leer_q;
      running_d   = (state_d == RUN);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         per_cnt_q   <= '0;
         period_q    <= '0;
         col_tmr_q   <= '0;
         col_q       <= '0;
         frame_q     <= '0;
         leer_q      <= 1'b0;
         dir_q       <= '0;
         col_valid_q <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         per_cnt_q   <= per_cnt_d;
         period_q    <= period_d;
         col_tmr_q   <= col_tmr_d;
         col_q       <= col_d;
         frame_q     <= frame_d;
         leer_q      <= leer_d;
         dir_q       <= dir_d;
         col_valid_q <= col_valid_d;
         running_q   <= running_d;
      end
   end

   assign leer_rom  = leer_q;
   assign dir_rom   = dir_q;
   assign col_valid = col_valid_q;
   assign running   = running_q;

endmodule
